// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall sequencer with memory-busy freeze, taken-branch
// flush and post-reset warm-up suppression.
// Optional build macro: HAZARD_STATS_EN adds stall/bubble/flush event counters.
module hazard_ctrl #(
    parameter int REGADDR_W    = 5,
    parameter int LOAD_LATENCY = 1,
    parameter int WARMUP       = 2,
    parameter int ZERO_REG     = 31
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REGADDR_W-1:0] id_rn,
    input  logic [REGADDR_W-1:0] id_rm,
    input  logic [REGADDR_W-1:0] id_rt,
    input  logic                 id_uses_rm,
    input  logic                 id_uses_rt,
    input  logic                 idex_memread,
    input  logic [REGADDR_W-1:0] idex_rd,
    input  logic                 br_taken,
    input  logic                 mem_busy,
    output logic                 stall,
    output logic                 pc_write,
    output logic                 ifid_write,
    output logic                 idex_bubble,
    output logic                 flush_ifid,
    output logic                 flush_idex,
    output logic                 freeze
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          bubble_events,
    output logic [31:0]          flush_events
`endif
);

    localparam int                   WW       = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
    localparam logic [WW-1:0]        WARM_MAX = WW'(WARMUP);
    localparam logic [2:0]           CNT_INIT = 3'(LOAD_LATENCY - 1);
    localparam logic [REGADDR_W-1:0] ZREG     = REGADDR_W'(ZERO_REG);
    localparam bit                   MULTI    = (LOAD_LATENCY > 1);

    typedef enum logic {
        IDLE,
        STALL
    } state_t;

    state_t        state;
    logic [2:0]    cnt;
    logic [WW-1:0] warm;
    logic          warm_done;
    logic          detect;
    logic          stall_req;

    assign warm_done = (warm >= WARM_MAX);

    // Load-use hazard: load in EX writes a register the ID instruction reads
    always_comb begin
        detect = warm_done && idex_memread && (idex_rd != ZREG) &&
                 ((id_rn == idex_rd) ||
                  (id_uses_rm && (id_rm == idex_rd)) ||
                  (id_uses_rt && (id_rt == idex_rd)));
        // detect only matters in IDLE; STALL already stalls unconditionally
        stall_req = (state == STALL) || detect;
    end

    // Pipeline control outputs, prioritised busy > branch > stall
    always_comb begin
        stall       = 1'b0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        freeze      = 1'b0;
        if (reset) begin
            // defaults: PC and IF/ID free-running, everything else quiet
        end else if (mem_busy) begin
            freeze     = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (br_taken) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (stall_req) begin
            stall       = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // Stall sequencer and reset-relative warm-up counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            warm  <= '0;
        end else begin
            // warm-up counts cycles since reset, independent of mem_busy
            if (warm < WARM_MAX) begin
                warm <= warm + 1'b1;
            end
            if (!mem_busy) begin
                if (br_taken) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            // first bubble is issued from IDLE; STALL covers the rest
                            if (detect && MULTI) begin
                                state <= STALL;
                                cnt   <= CNT_INIT;
                            end
                        end
                        STALL: begin
                            if (cnt <= 3'd1) begin
                                state <= IDLE;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt - 3'd1;
                            end
                        end
                        default: begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    endcase
                end
            end
        end
    end

`ifdef HAZARD_STATS_EN
    // Event counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles  <= '0;
            bubble_events <= '0;
            flush_events  <= '0;
        end else begin
            if (stall) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (stall && (state == IDLE)) begin
                bubble_events <= bubble_events + 32'd1;
            end
            if (flush_ifid) begin
                flush_events <= flush_events + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven checks of hazard_ctrl with LOAD_LATENCY=1 and
// LOAD_LATENCY=3 instances sharing the same stimulus.
module tb_hazard_ctrl;

    // output vector order: {stall, pc_write, ifid_write, idex_bubble, flush_ifid, flush_idex, freeze}
    localparam logic [6:0] N = 7'b0110000;
    localparam logic [6:0] S = 7'b1001000;
    localparam logic [6:0] F = 7'b0110110;
    localparam logic [6:0] Z = 7'b0000001;

    typedef struct {
        string      name;
        logic       rst;
        logic [4:0] rn;
        logic [4:0] rm;
        logic [4:0] rt;
        logic       urm;
        logic       urt;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       busy;
        logic [6:0] e1;
        logic [6:0] e3;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] id_rn = '0, id_rm = '0, id_rt = '0, idex_rd = '0;
    logic       id_uses_rm = 1'b0, id_uses_rt = 1'b0, idex_memread = 1'b0;
    logic       br_taken = 1'b0, mem_busy = 1'b0;

    logic st1, pc1, if1, bb1, fi1, fe1, fr1;
    logic st3, pc3, if3, bb3, fi3, fe3, fr3;
    logic [6:0] out1, out3;

    int unsigned num_checks = 0;
    int unsigned num_fail   = 0;
    vec_t        tbl[$];

`ifdef HAZARD_STATS_EN
    logic [31:0] sc1, be1, fl1, sc3, be3, fl3;
    int unsigned sb_stall = 0, sb_bub = 0, sb_flush = 0;
    bit          prev_stall = 0;
    bit          stats_valid = 0;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.REGADDR_W(5), .LOAD_LATENCY(1), .WARMUP(2), .ZERO_REG(31)) dut1 (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_rt(id_rt),
        .id_uses_rm(id_uses_rm), .id_uses_rt(id_uses_rt), .idex_memread(idex_memread),
        .idex_rd(idex_rd), .br_taken(br_taken), .mem_busy(mem_busy),
        .stall(st1), .pc_write(pc1), .ifid_write(if1), .idex_bubble(bb1),
        .flush_ifid(fi1), .flush_idex(fe1), .freeze(fr1)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(sc1), .bubble_events(be1), .flush_events(fl1)
`endif
    );

    hazard_ctrl #(.REGADDR_W(5), .LOAD_LATENCY(3), .WARMUP(2), .ZERO_REG(31)) dut3 (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_rt(id_rt),
        .id_uses_rm(id_uses_rm), .id_uses_rt(id_uses_rt), .idex_memread(idex_memread),
        .idex_rd(idex_rd), .br_taken(br_taken), .mem_busy(mem_busy),
        .stall(st3), .pc_write(pc3), .ifid_write(if3), .idex_bubble(bb3),
        .flush_ifid(fi3), .flush_idex(fe3), .freeze(fr3)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(sc3), .bubble_events(be3), .flush_events(fl3)
`endif
    );

    assign out1 = {st1, pc1, if1, bb1, fi1, fe1, fr1};
    assign out3 = {st3, pc3, if3, bb3, fi3, fe3, fr3};

    function automatic vec_t mk(string n, logic r, logic [4:0] rn, logic [4:0] rm, logic [4:0] rt,
                                logic urm, logic urt, logic mr, logic [4:0] rd, logic br,
                                logic busy, logic [6:0] e1, logic [6:0] e3);
        vec_t v;
        v.name = n; v.rst = r; v.rn = rn; v.rm = rm; v.rt = rt;
        v.urm = urm; v.urt = urt; v.mr = mr; v.rd = rd; v.br = br; v.busy = busy;
        v.e1 = e1; v.e3 = e3;
        return v;
    endfunction

    // shorthand rows
    function automatic vec_t idle(string n, logic [6:0] e1, logic [6:0] e3);
        return mk(n, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e1, e3);
    endfunction

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        reset = v.rst; id_rn = v.rn; id_rm = v.rm; id_rt = v.rt;
        id_uses_rm = v.urm; id_uses_rt = v.urt; idex_memread = v.mr; idex_rd = v.rd;
        br_taken = v.br; mem_busy = v.busy;
        #1;
        num_checks++;
        if (out1 !== v.e1) begin
            num_fail++;
            $display("FAIL %s lat1: got %b want %b", v.name, out1, v.e1);
        end
        num_checks++;
        if (out3 !== v.e3) begin
            num_fail++;
            $display("FAIL %s lat3: got %b want %b", v.name, out3, v.e3);
        end
`ifdef HAZARD_STATS_EN
        if (stats_valid) begin
            num_checks++;
            if (sc3 !== sb_stall || be3 !== sb_bub || fl3 !== sb_flush) begin
                num_fail++;
                $display("FAIL %s stats: got %0d/%0d/%0d want %0d/%0d/%0d",
                         v.name, sc3, be3, fl3, sb_stall, sb_bub, sb_flush);
            end
        end
        if (v.rst) begin
            sb_stall = 0; sb_bub = 0; sb_flush = 0; prev_stall = 0; stats_valid = 1;
        end else begin
            sb_stall += int'(v.e3[6]);
            sb_flush += int'(v.e3[2]);
            if (!v.e3[0]) begin
                if (v.e3[6] && !prev_stall) sb_bub++;
                prev_stall = v.e3[6];
            end
        end
`endif
    endtask

    initial begin
        // reset, warm-up and basic latency table
        tbl.push_back(mk("rst_hold",  1, 3, 0, 0, 0, 0, 1, 3, 0, 0, N, N));
        tbl.push_back(mk("warm0",     0, 3, 0, 0, 0, 0, 1, 3, 0, 0, N, N));
        tbl.push_back(mk("warm1",     0, 3, 0, 0, 0, 0, 1, 3, 0, 0, N, N));
        tbl.push_back(mk("warm_done", 0, 3, 0, 0, 0, 0, 1, 3, 0, 0, S, S));
        tbl.push_back(idle("lat_bub1", N, S));
        tbl.push_back(idle("lat_bub2", N, S));
        tbl.push_back(idle("lat_end",  N, N));
        tbl.push_back(mk("rm_haz",    0, 0, 5, 0, 1, 0, 1, 5, 0, 0, S, S));
        tbl.push_back(idle("rm_bub1", N, S));
        tbl.push_back(idle("rm_bub2", N, S));
        tbl.push_back(idle("rm_end",  N, N));
        tbl.push_back(mk("rm_unused", 0, 0, 5, 0, 0, 0, 1, 5, 0, 0, N, N));
        tbl.push_back(mk("rt_haz",    0, 1, 0, 7, 0, 1, 1, 7, 0, 0, S, S));
        tbl.push_back(idle("rt_bub1", N, S));
        tbl.push_back(idle("rt_bub2", N, S));
        tbl.push_back(idle("rt_end",  N, N));
        tbl.push_back(mk("rt_unused", 0, 1, 0, 7, 0, 0, 1, 7, 0, 0, N, N));
        tbl.push_back(mk("xzr",       0, 31, 31, 31, 1, 1, 1, 31, 0, 0, N, N));
        tbl.push_back(mk("no_load",   0, 7, 0, 0, 0, 0, 0, 7, 0, 0, N, N));
        tbl.push_back(mk("br_haz",    0, 1, 0, 7, 0, 1, 1, 7, 0, 0, S, S));
        tbl.push_back(mk("br_abort",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, F, F));
        tbl.push_back(idle("br_after", N, N));
        tbl.push_back(mk("br_over_haz", 0, 3, 0, 0, 0, 0, 1, 3, 1, 0, F, F));
        tbl.push_back(idle("br_haz_after", N, N));

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i]);
        end

        // mem_busy freezes a STALL with cnt=2; two bubbles remain afterwards
        run_vec(mk("bz_haz", 0, 1, 0, 7, 0, 1, 1, 7, 0, 0, S, S));
        for (int k = 0; k < 4; k++) begin
            run_vec(mk("bz_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, Z, Z));
        end
        run_vec(idle("bz_rel1", N, S));
        run_vec(idle("bz_rel2", N, S));
        run_vec(idle("bz_end",  N, N));
        run_vec(mk("bz_over_haz", 0, 3, 0, 0, 0, 0, 1, 3, 0, 1, Z, Z));
        run_vec(mk("bz_over_br",  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, Z, Z));
        run_vec(mk("br_only",     0, 0, 0, 0, 0, 0, 0, 0, 1, 0, F, F));
        run_vec(idle("bz_quiet", N, N));

        // reset during STALL: no resume, warm-up restarts
        run_vec(mk("rs_haz",   0, 3, 0, 0, 0, 0, 1, 3, 0, 0, S, S));
        run_vec(mk("rs_mid",   1, 3, 0, 0, 0, 0, 1, 3, 0, 0, N, N));
        run_vec(idle("rs_post", N, N));
        run_vec(mk("rs_warm1", 0, 3, 0, 0, 0, 0, 1, 3, 0, 0, N, N));
        run_vec(mk("rs_warm2", 0, 3, 0, 0, 0, 0, 1, 3, 0, 0, S, S));
        run_vec(idle("rs_bub1", N, S));
        run_vec(idle("rs_bub2", N, S));
        run_vec(idle("rs_end",  N, N));

`ifdef HAZARD_STATS_EN
        // reset clears every counter
        run_vec(mk("st_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, N, N));
        run_vec(idle("st_zero", N, N));
`endif

        $display("[TB] %0d tests run, %0d failed", num_checks, num_fail);
        $finish;
    end

endmodule
